// File: rtl/countdown_timer_ctrl_if.sv
// Control/status bundle between appliance controller and the countdown timer.
interface countdown_timer_ctrl_if #(
  parameter int unsigned MODE_W = 3
);

  logic [MODE_W-1:0] mode_state;
  logic              start;
  logic              pause;
  logic              load;
  logic [5:0]        load_min;
  logic [5:0]        load_sec;

  logic              busy;
  logic              paused;
  logic              done;
  logic              done_pulse;
  logic [5:0]        min_out;
  logic [5:0]        sec_out;
  logic [31:0]       time_data;

  // Appliance controller side: drives commands, observes timer status.
  modport master (
    output mode_state, start, pause, load, load_min, load_sec,
    input  busy, paused, done, done_pulse, min_out, sec_out, time_data
  );

  // Timer side: consumes commands, reports status.
  modport slave (
    input  mode_state, start, pause, load, load_min, load_sec,
    output busy, paused, done, done_pulse, min_out, sec_out, time_data
  );

endinterface

// File: rtl/countdown_timer_ctrl.sv
// mm:ss countdown engine with load/start/pause, prescaled 1 s tick and BCD display word.
module countdown_timer_ctrl #(
  parameter int unsigned       TICK_DIV    = 100_000_000,
  parameter int unsigned       MODE_W      = 3,
  parameter logic [MODE_W-1:0] ACTIVE_MODE = 3'b100,
  parameter int unsigned       DEFAULT_MIN = 3,
  parameter int unsigned       DEFAULT_SEC = 0,
  parameter int unsigned       MAX_MIN     = 59
) (
  input  logic                   clk,
  input  logic                   rst,
  countdown_timer_ctrl_if.slave  ctrl_if
);

  localparam int unsigned       PRESC_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
  localparam logic [5:0]        DEF_MIN    = 6'(DEFAULT_MIN);
  localparam logic [5:0]        DEF_SEC    = 6'(DEFAULT_SEC);
  localparam logic [5:0]        MIN_CLAMP  = 6'(MAX_MIN);
  localparam logic [5:0]        SEC_CLAMP  = 6'd59;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSE,
    ST_DONE
  } state_e;

  state_e               state_q;
  logic [5:0]           min_q;
  logic [5:0]           sec_q;
  logic [5:0]           ld_min_q;
  logic [5:0]           ld_sec_q;
  logic [PRESC_W-1:0]   presc_q;
  logic                 busy_q;
  logic                 paused_q;
  logic                 done_q;
  logic                 done_pulse_q;
  logic [31:0]          time_data_q;
  logic [31:0]          time_data_d;

  logic                 active_c;
  logic                 load_ok_c;
  logic                 tick_c;
  logic [5:0]           ld_min_c;
  logic [5:0]           ld_sec_c;
  logic                 ld_zero_c;

  // Command qualification, load clamping and prescaler terminal count.
  always_comb begin
    active_c  = (ctrl_if.mode_state == ACTIVE_MODE);
    load_ok_c = ctrl_if.load && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    tick_c    = (state_q == ST_RUN) && (presc_q == PRESC_LAST);
    ld_min_c  = (ctrl_if.load_min > MIN_CLAMP) ? MIN_CLAMP : ctrl_if.load_min;
    ld_sec_c  = (ctrl_if.load_sec > SEC_CLAMP) ? SEC_CLAMP : ctrl_if.load_sec;
    ld_zero_c = (ld_min_q == 6'd0) && (ld_sec_q == 6'd0);
  end

  // Control FSM and time counters; one event per edge, highest priority first.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      min_q        <= DEF_MIN;
      sec_q        <= DEF_SEC;
      ld_min_q     <= DEF_MIN;
      ld_sec_q     <= DEF_SEC;
      presc_q      <= '0;
      busy_q       <= 1'b0;
      paused_q     <= 1'b0;
      done_q       <= 1'b0;
      done_pulse_q <= 1'b0;
    end else begin
      done_pulse_q <= 1'b0;
      if (!active_c) begin
        // Leaving the timed mode abandons the countdown silently.
        state_q  <= ST_IDLE;
        min_q    <= DEF_MIN;
        sec_q    <= DEF_SEC;
        ld_min_q <= DEF_MIN;
        ld_sec_q <= DEF_SEC;
        presc_q  <= '0;
        busy_q   <= 1'b0;
        paused_q <= 1'b0;
        done_q   <= 1'b0;
      end else if (load_ok_c) begin
        state_q  <= ST_IDLE;
        min_q    <= ld_min_c;
        sec_q    <= ld_sec_c;
        ld_min_q <= ld_min_c;
        ld_sec_q <= ld_sec_c;
        busy_q   <= 1'b0;
        paused_q <= 1'b0;
        done_q   <= 1'b0;
      end else if (ctrl_if.start) begin
        // Start always restarts from the last loaded value.
        presc_q  <= '0;
        min_q    <= ld_min_q;
        sec_q    <= ld_sec_q;
        paused_q <= 1'b0;
        if (ld_zero_c) begin
          state_q      <= ST_DONE;
          busy_q       <= 1'b0;
          done_q       <= 1'b1;
          done_pulse_q <= 1'b1;
        end else begin
          state_q <= ST_RUN;
          busy_q  <= 1'b1;
          done_q  <= 1'b0;
        end
      end else if (ctrl_if.pause && (state_q == ST_RUN)) begin
        state_q  <= ST_PAUSE;
        paused_q <= 1'b1;
      end else if (ctrl_if.pause && (state_q == ST_PAUSE)) begin
        state_q  <= ST_RUN;
        paused_q <= 1'b0;
      end else if (state_q == ST_RUN) begin
        if (tick_c) begin
          presc_q <= '0;
          if (sec_q != 6'd0) begin
            sec_q <= sec_q - 6'd1;
            if ((min_q == 6'd0) && (sec_q == 6'd1)) begin
              state_q      <= ST_DONE;
              busy_q       <= 1'b0;
              done_q       <= 1'b1;
              done_pulse_q <= 1'b1;
            end
          end else begin
            min_q <= min_q - 6'd1;
            sec_q <= SEC_CLAMP;
          end
        end else begin
          presc_q <= presc_q + PRESC_W'(1);
        end
      end
    end
  end

  // Packed BCD display word built from the current binary time.
  always_comb begin
    time_data_d = {8'h00,
                   4'hF, 4'(min_q / 6'd10), 4'(min_q % 6'd10),
                   4'hF, 4'(sec_q / 6'd10), 4'(sec_q % 6'd10)};
  end

  // Display register; follows min/sec with one cycle of latency.
  always_ff @(posedge clk) begin
    time_data_q <= time_data_d;
  end

  assign ctrl_if.busy       = busy_q;
  assign ctrl_if.paused     = paused_q;
  assign ctrl_if.done       = done_q;
  assign ctrl_if.done_pulse = done_pulse_q;
  assign ctrl_if.min_out    = min_q;
  assign ctrl_if.sec_out    = sec_q;
  assign ctrl_if.time_data  = time_data_q;

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Scoreboard bench for countdown_timer_ctrl: total-seconds reference model, directed + random stimulus.
module tb_countdown_timer_ctrl;

  localparam int          TD      = 4;
  localparam logic [2:0]  ACT     = 3'b100;
  localparam int          DEF_TOT = 3 * 60;

  logic clk;
  logic rst;

  countdown_timer_ctrl_if #(.MODE_W(3)) bus ();

  countdown_timer_ctrl #(
    .TICK_DIV(TD), .MODE_W(3), .ACTIVE_MODE(ACT),
    .DEFAULT_MIN(3), .DEFAULT_SEC(0), .MAX_MIN(59)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ctrl_if(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        busy;
    logic        paused;
    logic        done;
    logic        pulse;
    logic [5:0]  mn;
    logic [5:0]  sc;
    logic [31:0] td;
    bit          td_valid;
    int          step_no;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_cnt = 0;

  // Reference model: remaining time as a total number of seconds.
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
  int m_state  = M_IDLE;
  int m_total  = DEF_TOT;
  int m_loaded = DEF_TOT;
  int m_phase  = 0;
  bit m_pulse  = 0;
  bit m_known  = 0;

  function automatic logic [31:0] td_of(input int t);
    int m, s;
    m = t / 60;
    s = t % 60;
    return {8'h00, 4'hF, 4'(m / 10), 4'(m % 10), 4'hF, 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic model_edge(input logic r, input logic [2:0] md, input logic s,
                            input logic p, input logic l, input int lm, input int ls);
    exp_t e;
    e.td       = m_known ? td_of(m_total) : 32'h0;
    e.td_valid = m_known;
    m_pulse = 0;
    if (!r || md != ACT) begin
      m_state = M_IDLE; m_total = DEF_TOT; m_loaded = DEF_TOT; m_phase = 0;
    end else if (l && (m_state == M_IDLE || m_state == M_DONE)) begin
      m_loaded = ((lm > 59) ? 59 : lm) * 60 + ((ls > 59) ? 59 : ls);
      m_total  = m_loaded;
      m_state  = M_IDLE;
    end else if (s) begin
      m_phase = 0;
      m_total = m_loaded;
      if (m_total == 0) begin m_state = M_DONE; m_pulse = 1; end
      else m_state = M_RUN;
    end else if (p && m_state == M_RUN) begin
      m_state = M_PAUSE;
    end else if (p && m_state == M_PAUSE) begin
      m_state = M_RUN;
    end else if (m_state == M_RUN) begin
      if (m_phase == TD - 1) begin
        m_phase = 0;
        m_total = m_total - 1;
        if (m_total == 0) begin m_state = M_DONE; m_pulse = 1; end
      end else begin
        m_phase = m_phase + 1;
      end
    end
    m_known  = 1;
    e.busy   = (m_state == M_RUN) || (m_state == M_PAUSE);
    e.paused = (m_state == M_PAUSE);
    e.done   = (m_state == M_DONE);
    e.pulse  = m_pulse;
    e.mn     = 6'(m_total / 60);
    e.sc     = 6'(m_total % 60);
    e.step_no = step_cnt;
    exp_q.push_back(e);
  endtask

  // One clock of stimulus: drive away from the edge, record the expected post-edge state.
  task automatic step(input logic r, input logic [2:0] md, input logic s, input logic p,
                      input logic l, input int lm, input int ls);
    @(negedge clk);
    step_cnt++;
    rst              = r;
    bus.mode_state   = md;
    bus.start        = s;
    bus.pause        = p;
    bus.load         = l;
    bus.load_min     = 6'(lm);
    bus.load_sec     = 6'(ls);
    model_edge(r, md, s, p, l, lm, ls);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, ACT, 1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  // Direct spot check of the output just produced by the last step's edge.
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, got, req, $time);
    end
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  // Monitor: compares every DUT output cycle against the scoreboard entry for that edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if (bus.busy !== e.busy || bus.paused !== e.paused || bus.done !== e.done ||
            bus.done_pulse !== e.pulse || bus.min_out !== e.mn || bus.sec_out !== e.sc ||
            (e.td_valid && bus.time_data !== e.td)) begin
          errors++;
          $display("FAIL step%0d: got b%b p%b d%b dp%b %0d:%0d td=%h, required b%b p%b d%b dp%b %0d:%0d td=%h",
                   e.step_no, bus.busy, bus.paused, bus.done, bus.done_pulse, bus.min_out,
                   bus.sec_out, bus.time_data, e.busy, e.paused, e.done, e.pulse, e.mn, e.sc,
                   e.td_valid ? e.td : 32'h0);
        end
      end
    end
  end

  initial begin
    logic [2:0] cur_mode;
    logic       r, s, p, l;
    int         lm, ls;

    rst = 1'b0;
    bus.mode_state = ACT;
    bus.start = 1'b0; bus.pause = 1'b0; bus.load = 1'b0;
    bus.load_min = 6'd0; bus.load_sec = 6'd0;

    // Reset, then idle in the active mode.
    for (int i = 0; i < 3; i++) step(1'b0, ACT, 1'b0, 1'b0, 1'b0, 0, 0);
    idle(20);
    after_edge();
    chk("idle_time_data", bus.time_data, 32'h00F03F00);
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("idle_done", 32'(bus.done), 32'd0);

    // 0:02 run to completion.
    step(1'b1, ACT, 1'b0, 1'b0, 1'b1, 0, 2);
    step(1'b1, ACT, 1'b1, 1'b0, 1'b0, 0, 0);
    idle(10);

    // 1:00 rolls to 0:59 on the first tick.
    step(1'b1, ACT, 1'b0, 1'b0, 1'b1, 1, 0);
    step(1'b1, ACT, 1'b1, 1'b0, 1'b0, 0, 0);
    idle(5);
    after_edge();
    chk("roll_min", 32'(bus.min_out), 32'd0);
    chk("roll_sec", 32'(bus.sec_out), 32'd59);
    chk("roll_time_data", bus.time_data, 32'h00F00F59);

    // Pause at prescaler 2, hold, resume.
    step(1'b1, 3'b001, 1'b0, 1'b0, 1'b0, 0, 0);
    step(1'b1, ACT, 1'b0, 1'b0, 1'b1, 0, 5);
    step(1'b1, ACT, 1'b1, 1'b0, 1'b0, 0, 0);
    idle(2);
    step(1'b1, ACT, 1'b0, 1'b1, 1'b0, 0, 0);
    idle(50);
    after_edge();
    chk("pause_held_sec", 32'(bus.sec_out), 32'd5);
    chk("pause_flag", 32'(bus.paused), 32'd1);
    step(1'b1, ACT, 1'b0, 1'b1, 1'b0, 0, 0);
    idle(30);

    // Mode exit mid-run.
    step(1'b1, ACT, 1'b0, 1'b0, 1'b1, 2, 10);
    step(1'b1, ACT, 1'b1, 1'b0, 1'b0, 0, 0);
    idle(6);
    step(1'b1, 3'b001, 1'b0, 1'b0, 1'b0, 0, 0);
    after_edge();
    chk("exit_busy", 32'(bus.busy), 32'd0);
    chk("exit_min", 32'(bus.min_out), 32'd3);
    chk("exit_pulse", 32'(bus.done_pulse), 32'd0);

    // Clamp, zero start, reset mid-run.
    step(1'b1, ACT, 1'b0, 1'b0, 1'b1, 63, 61);
    after_edge();
    chk("clamp_min", 32'(bus.min_out), 32'd59);
    chk("clamp_sec", 32'(bus.sec_out), 32'd59);
    step(1'b1, ACT, 1'b0, 1'b0, 1'b1, 0, 0);
    step(1'b1, ACT, 1'b1, 1'b0, 1'b0, 0, 0);
    after_edge();
    chk("zero_start_pulse", 32'(bus.done_pulse), 32'd1);
    chk("zero_start_done", 32'(bus.done), 32'd1);
    idle(3);
    step(1'b1, ACT, 1'b0, 1'b0, 1'b1, 1, 0);
    step(1'b1, ACT, 1'b1, 1'b0, 1'b0, 0, 0);
    idle(5);
    step(1'b0, ACT, 1'b0, 1'b0, 1'b0, 0, 0);
    after_edge();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_min", 32'(bus.min_out), 32'd3);
    idle(2);

    // Randomized traffic.
    cur_mode = ACT;
    for (int i = 0; i < 3000; i++) begin
      if (cur_mode == ACT) begin
        if ($urandom_range(0, 199) == 0) cur_mode = 3'($urandom_range(0, 3));
      end else if ($urandom_range(0, 19) == 0) begin
        cur_mode = ACT;
      end
      r  = ($urandom_range(0, 399) != 0);
      s  = ($urandom_range(0, 59) == 0);
      p  = ($urandom_range(0, 29) == 0);
      l  = ($urandom_range(0, 39) == 0);
      lm = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 1));
      ls = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 5));
      step(r, cur_mode, s, p, l, lm, ls);
    end
    idle(2);
    after_edge();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
